fwd_hazard_scoreboard: RTL and testbench

Parametrised operand-forwarding and load-use interlock unit for the pipelined MIPS32 core. It tracks the destination registers of in-flight instructions in an internal shadow pipeline, a shift register with one entry per forwarding stage. From that state it computes per-source forwarding selects for the instruction leaving ID, registers them into EX, and raises a stall when a producer's result is not yet on any forwarding bus. It sits beside the ID/EX pipeline register and drives the EX-stage operand muxes and the IF/ID hold logic.

---
 rtl/fwd_hazard_scoreboard_if.sv | 29 ++
 rtl/fwd_hazard_scoreboard.sv | 90 +++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_scoreboard_if.sv
// fwd_hazard_scoreboard_if: ID-stage request and EX-stage forwarding/stall signals of the hazard scoreboard
interface fwd_hazard_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 16
);
    localparam int SW = $clog2(DEPTH + 1);
    logic                  id_valid;
    logic [NUM_SRC*AW-1:0] id_src_addr;
    logic [NUM_SRC-1:0]    id_src_used;
    logic [AW-1:0]         id_rd;
    logic                  id_we;
    logic [SW-1:0]         id_lat;
    logic                  hold;
    logic                  flush;
    logic                  stall;
    logic                  ex_valid;
    logic [NUM_SRC*SW-1:0] ex_fwd_sel;
    logic [CNT_W-1:0]      stall_count;
    modport master (
        output id_valid, id_src_addr, id_src_used, id_rd, id_we, id_lat, hold, flush,
        input  stall, ex_valid, ex_fwd_sel, stall_count
    );
    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_rd, id_we, id_lat, hold, flush,
        output stall, ex_valid, ex_fwd_sel, stall_count
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: operand forwarding selects and load-use interlock from a shadow pipeline of in-flight destinations
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic rst,
    fwd_hazard_scoreboard_if.slave sb
);
    localparam int SW = $clog2(DEPTH + 1);
    logic [DEPTH:1]        v_q, v_d;
    logic [AW-1:0]         rd_q [1:DEPTH];
    logic [AW-1:0]         rd_d [1:DEPTH];
    logic [SW-1:0]         lat_q [1:DEPTH];
    logic [SW-1:0]         lat_d [1:DEPTH];
    logic                  ex_valid_q, ex_valid_d;
    logic [NUM_SRC*SW-1:0] ex_sel_q, ex_sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SRC*SW-1:0] sel;
    logic [NUM_SRC-1:0]    not_ready;
    logic [SW-1:0]         lat_in;
    logic                  stall;
    logic                  kill;

    // Resolve each source; scanning oldest to youngest lets the youngest producer overwrite older matches.
    always_comb begin
        sel = '0;
        not_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (sb.id_valid && sb.id_src_used[i] && sb.id_src_addr[i*AW +: AW] != '0 &&
                    v_q[k] && rd_q[k] == sb.id_src_addr[i*AW +: AW]) begin
                    sel[i*SW +: SW] = k >= int'(lat_q[k]) ? SW'(k) : '0;
                    not_ready[i] = k < int'(lat_q[k]);
                end
            end
        end
    end

    assign stall  = sb.id_valid & ~sb.flush & ~sb.hold & (|not_ready);
    assign kill   = stall | sb.flush;
    assign lat_in = sb.id_lat == '0 ? SW'(1) : (int'(sb.id_lat) > DEPTH ? SW'(DEPTH) : sb.id_lat);

    // Next state: everything freezes on hold, otherwise the shadow pipeline shifts and takes the ID instruction or a bubble.
    always_comb begin
        v_d = v_q;
        rd_d = rd_q;
        lat_d = lat_q;
        ex_valid_d = ex_valid_q;
        ex_sel_d = ex_sel_q;
        cnt_d = cnt_q;
        if (!sb.hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                v_d[k] = v_q[k-1];
                rd_d[k] = rd_q[k-1];
                lat_d[k] = lat_q[k-1];
            end
            v_d[1] = ~kill & sb.id_valid & sb.id_we & (sb.id_rd != '0);
            rd_d[1] = sb.id_rd;
            lat_d[1] = lat_in;
            ex_valid_d = ~kill & sb.id_valid;
            ex_sel_d = kill ? '0 : sel;
            cnt_d = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    // State registers; rd/lat payloads need no reset because v gates every use.
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
        lat_q <= lat_d;
        if (rst) begin
            v_q <= '0;
            ex_valid_q <= 1'b0;
            ex_sel_q <= '0;
            cnt_q <= '0;
        end else begin
            v_q <= v_d;
            ex_valid_q <= ex_valid_d;
            ex_sel_q <= ex_sel_d;
            cnt_q <= cnt_d;
        end
    end

    assign sb.stall       = stall;
    assign sb.ex_valid    = ex_valid_q;
    assign sb.ex_fwd_sel  = ex_sel_q;
    assign sb.stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: directed forwarding/interlock scenarios checked against a per-register last-writer model
module tb_fwd_hazard_scoreboard;
    localparam int NUM_SRC = 2;
    localparam int AW      = 5;
    localparam int DEPTH   = 3;
    localparam int SW      = 2;
    localparam int NREG    = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic                  id_valid;
    logic [NUM_SRC*AW-1:0] id_src_addr;
    logic [NUM_SRC-1:0]    id_src_used;
    logic [AW-1:0]         id_rd;
    logic                  id_we;
    logic [SW-1:0]         id_lat;
    logic                  hold;
    logic                  flush;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fwd_hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .AW(AW), .DEPTH(DEPTH), .CNT_W(16)) ifc ();
    fwd_hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .AW(AW), .DEPTH(DEPTH), .CNT_W(2))  ifs ();

    assign ifc.id_valid = id_valid;  assign ifs.id_valid = id_valid;
    assign ifc.id_src_addr = id_src_addr;  assign ifs.id_src_addr = id_src_addr;
    assign ifc.id_src_used = id_src_used;  assign ifs.id_src_used = id_src_used;
    assign ifc.id_rd = id_rd;  assign ifs.id_rd = id_rd;
    assign ifc.id_we = id_we;  assign ifs.id_we = id_we;
    assign ifc.id_lat = id_lat;  assign ifs.id_lat = id_lat;
    assign ifc.hold = hold;  assign ifs.hold = hold;
    assign ifc.flush = flush;  assign ifs.flush = flush;

    fwd_hazard_scoreboard #(.NUM_SRC(NUM_SRC), .AW(AW), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sb(ifc.slave));
    fwd_hazard_scoreboard #(.NUM_SRC(NUM_SRC), .AW(AW), .DEPTH(DEPTH), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .sb(ifs.slave));

    // Model: per register, the issue time of its youngest in-flight writer; time advances on every non-held edge.
    bit m_started = 1'b0;
    int m_t;
    bit m_v [NREG];
    int m_iss [NREG];
    int m_lat [NREG];
    bit m_exv;
    int m_sel [NUM_SRC];
    int m_cnt;
    bit m_st;
    bit m_kill;

    function automatic int src_sel(int i);
        int r;
        int d;
        r = int'(id_src_addr[i*AW +: AW]);
        if (!id_valid || !id_src_used[i] || r == 0 || !m_v[r]) return 0;
        d = m_t - m_iss[r] + 1;
        if (d > DEPTH) return 0;
        return d >= m_lat[r] ? d : -1;
    endfunction

    function automatic bit exp_stall();
        bit nr = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) if (src_sel(i) < 0) nr = 1'b1;
        return id_valid && !flush && !hold && nr;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1'b1;
            m_t = 0;
            foreach (m_v[r]) m_v[r] = 1'b0;
            m_exv = 1'b0;
            foreach (m_sel[i]) m_sel[i] = 0;
            m_cnt = 0;
        end else if (!hold) begin
            m_st = exp_stall();
            m_kill = m_st || flush;
            for (int i = 0; i < NUM_SRC; i++) m_sel[i] = m_kill ? 0 : src_sel(i);
            m_exv = !m_kill && id_valid;
            m_t++;
            if (!m_kill && id_valid && id_we && id_rd != 0) begin
                m_v[id_rd] = 1'b1;
                m_iss[id_rd] = m_t;
                m_lat[id_rd] = id_lat == 0 ? 1 : (int'(id_lat) > DEPTH ? DEPTH : int'(id_lat));
            end
            if (m_st) m_cnt++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sel_of(int i);
        return int'(ifc.ex_fwd_sel[i*SW +: SW]);
    endfunction

    // Every cycle after reset, outputs of both instances must agree with the model.
    always @(negedge clk) begin
        if (m_started) begin
            chk("m_stall", int'(ifc.stall), int'(exp_stall()));
            chk("m_stall_s", int'(ifs.stall), int'(exp_stall()));
            chk("m_ex_valid", int'(ifc.ex_valid), int'(m_exv));
            for (int i = 0; i < NUM_SRC; i++) chk("m_ex_sel", sel_of(i), m_sel[i]);
            chk("m_count", int'(ifc.stall_count), m_cnt);
            chk("m_count_sat", int'(ifs.stall_count), m_cnt > 3 ? 3 : m_cnt);
        end
    end

    task automatic set(input int v, input int s0, input int s1, input int used, input int rd,
                       input int we, input int lat, input int h, input int f);
        id_valid = v[0];
        id_src_addr = {AW'(s1), AW'(s0)};
        id_src_used = NUM_SRC'(used);
        id_rd = AW'(rd);
        id_we = we[0];
        id_lat = SW'(lat);
        hold = h[0];
        flush = f[0];
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input int rd, input int lat);
        set(1, 0, 0, 0, rd, 1, lat, 0, 0);
        adv();
    endtask

    task automatic use_src(input int s0, input int s1, input int used);
        set(1, s0, s1, used, 0, 0, 1, 0, 0);
    endtask

    initial begin
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_stall", int'(ifc.stall), 0);
        chk("rst_ex_valid", int'(ifc.ex_valid), 0);
        chk("rst_sel", int'(ifc.ex_fwd_sel), 0);
        chk("rst_count", int'(ifc.stall_count), 0);

        ins(3, 1); use_src(3, 0, 1);
        chk("alu_b2b_stall", int'(ifc.stall), 0);
        adv();
        chk("alu_b2b_sel0", sel_of(0), 1);
        chk("alu_b2b_exv", int'(ifc.ex_valid), 1);

        ins(3, 1); ins(9, 1); use_src(3, 0, 1);
        chk("alu_d2_stall", int'(ifc.stall), 0);
        adv();
        chk("alu_d2_sel0", sel_of(0), 2);

        ins(5, 2); use_src(0, 5, 2);
        chk("load_use_stall", int'(ifc.stall), 1);
        adv();
        chk("load_use_count", int'(ifc.stall_count), 1);
        chk("load_use_bubble", int'(ifc.ex_valid), 0);
        chk("load_use_resolved", int'(ifc.stall), 0);
        adv();
        chk("load_use_sel1", sel_of(1), 2);
        chk("load_use_exv", int'(ifc.ex_valid), 1);

        ins(7, 1); ins(7, 1); use_src(7, 0, 1);
        chk("youngest_stall", int'(ifc.stall), 0);
        adv();
        chk("youngest_sel0", sel_of(0), 1);

        ins(0, 1); use_src(0, 0, 3);
        chk("r0_stall", int'(ifc.stall), 0);
        adv();
        chk("r0_sel", int'(ifc.ex_fwd_sel), 0);
        ins(4, 1); use_src(4, 4, 0);
        chk("unused_stall", int'(ifc.stall), 0);
        adv();
        chk("unused_sel", int'(ifc.ex_fwd_sel), 0);
        chk("unused_exv", int'(ifc.ex_valid), 1);

        ins(1, 2); ins(2, 1); use_src(1, 2, 3);
        chk("two_src_stall", int'(ifc.stall), 0);
        adv();
        chk("two_src_sel0", sel_of(0), 2);
        chk("two_src_sel1", sel_of(1), 1);
        ins(1, 1); ins(2, 2); use_src(1, 2, 3);
        chk("two_src_hz_stall", int'(ifc.stall), 1);
        adv(); adv();

        ins(8, 0); use_src(8, 0, 1);
        chk("lat0_stall", int'(ifc.stall), 0);
        adv();
        chk("lat0_sel0", sel_of(0), 1);

        ins(5, 2);
        set(1, 0, 5, 2, 0, 0, 1, 1, 0);
        chk("hold_stall", int'(ifc.stall), 0);
        repeat (3) begin
            adv();
            chk("hold_count", int'(ifc.stall_count), 2);
        end
        use_src(0, 5, 2);
        chk("after_hold_stall", int'(ifc.stall), 1);
        adv();
        chk("after_hold_count", int'(ifc.stall_count), 3);
        chk("after_hold_resolved", int'(ifc.stall), 0);
        adv();
        chk("after_hold_sel1", sel_of(1), 2);

        ins(5, 2);
        set(1, 0, 5, 2, 0, 0, 1, 0, 1);
        chk("flush_stall", int'(ifc.stall), 0);
        adv();
        chk("flush_exv", int'(ifc.ex_valid), 0);
        chk("flush_count", int'(ifc.stall_count), 3);
        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();

        ins(6, 2); use_src(6, 0, 1);
        chk("pre_rst_stall", int'(ifc.stall), 1);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        chk("mid_rst_exv", int'(ifc.ex_valid), 0);
        chk("mid_rst_sel", int'(ifc.ex_fwd_sel), 0);
        chk("mid_rst_count", int'(ifc.stall_count), 0);
        chk("mid_rst_stall", int'(ifc.stall), 0);
        adv();
        chk("post_rst_sel0", sel_of(0), 0);
        chk("post_rst_exv", int'(ifc.ex_valid), 1);

        repeat (5) begin
            ins(5, 2); use_src(0, 5, 2);
            adv(); adv();
        end
        chk("sat_count16", int'(ifc.stall_count), 5);
        chk("sat_count2", int'(ifs.stall_count), 3);

        set(0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); adv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
